muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 44 ++++
 rtl/muldiv_core_iter.sv | 50 +++++
 rtl/muldiv_unit.sv | 211 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV64M
// multiply/divide unit.
//   op_e    - funct3 encoding of the eight M-extension operations
//   state_e - control FSM states of muldiv_unit
//   helpers - operand signedness and divide-class decode
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [XLEN_DEFAULT-1:0] MIN_SIGNED = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};
  localparam logic [XLEN_DEFAULT-1:0] ALL_ONES   = {XLEN_DEFAULT{1'b1}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic op_is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic op_rs1_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_rs2_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_core_iter.sv
// muldiv_core_iter: one combinational iteration of the unsigned datapath.
//   is_mul_i     - 1: shift-add multiply step, 0: restoring divide step
//   acc_i/acc_o  - product high half (multiply) or partial remainder (divide)
//   sh_i/sh_o    - multiplier/product low half, or dividend/quotient shifter
//   opb_i        - multiplicand or divisor magnitude
module muldiv_core_iter #(
  parameter int XLEN = 64
) (
  input  logic            is_mul_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] sh_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] sh_o
);

  logic [XLEN:0] add_s;
  logic [XLEN:0] sum_s;
  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // Single multiply or divide step selected by is_mul_i.
  always_comb begin
    add_s     = {1'b0, acc_i} + {1'b0, opb_i};
    // Remainder shifted left with the next dividend bit; bit XLEN is the guard bit.
    shifted_s = {acc_i, sh_i[XLEN-1]};
    diff_s    = shifted_s - {1'b0, opb_i};
    sum_s     = {1'b0, acc_i};
    acc_o     = acc_i;
    sh_o      = sh_i;
    if (is_mul_i) begin
      if (sh_i[0]) begin
        sum_s = add_s;
      end else begin
        sum_s = {1'b0, acc_i};
      end
      // Shift the whole {carry, acc, sh} product right by one.
      acc_o = sum_s[XLEN:1];
      sh_o  = {sum_s[0], sh_i[XLEN-1:1]};
    end else if (!diff_s[XLEN]) begin
      // Partial remainder < divisor keeps a non-negative difference below 2^XLEN.
      acc_o = diff_s[XLEN-1:0];
      sh_o  = {sh_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = shifted_s[XLEN-1:0];
      sh_o  = {sh_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit, one op in flight.
//   in_valid/in_ready/in_op/in_rd/in_rs1_data/in_rs2_data - request side
//   out_valid/out_ready/out_rd/out_result                 - writeback side
//   flush  - drops the in-flight (or same-cycle accepted) op
//   rst_n  - synchronous active-low reset
// Operands are converted to magnitudes at accept, iterated unsigned for XLEN
// cycles, sign-fixed in FIX, then held in DONE until the writeback takes them.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result
);

  localparam logic [XLEN-1:0] MIN_S  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_S = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_S = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  op_e               op_in_s;
  logic              s1_s, s2_s, div0_s, ovf_s, special_s;
  logic [XLEN-1:0]   mag1_s, mag2_s, special_res_s;
  logic [XLEN-1:0]   hi_nxt_s, lo_nxt_s, fix_res_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s;

  // Accept-side decode: signs, magnitudes and the no-iteration divide cases.
  always_comb begin
    op_in_s   = op_e'(in_op);
    s1_s      = op_rs1_signed(op_in_s) & in_rs1_data[XLEN-1];
    s2_s      = op_rs2_signed(op_in_s) & in_rs2_data[XLEN-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    mag1_s    = s1_s ? -in_rs1_data : in_rs1_data;
    mag2_s    = s2_s ? -in_rs2_data : in_rs2_data;
    div0_s    = (in_rs2_data == ZERO_S);
    ovf_s     = (op_in_s inside {OP_DIV, OP_REM}) && (in_rs1_data == MIN_S) &&
                (in_rs2_data == ONES_S);
    special_s = op_is_div(op_in_s) && (div0_s || ovf_s);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (div0_s) begin
      special_res_s = in_op[1] ? in_rs1_data : ONES_S;
    end else begin
      special_res_s = in_op[1] ? ZERO_S : in_rs1_data;
    end
  end

  muldiv_core_iter #(.XLEN(XLEN)) u_iter (
    .is_mul_i (!op_is_div(op_q)),
    .acc_i    (hi_q),
    .sh_i     (lo_q),
    .opb_i    (opb_q),
    .acc_o    (hi_nxt_s),
    .sh_o     (lo_nxt_s)
  );

  // Sign fix-up and result selection used in FIX.
  always_comb begin
    prod_fix_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix_s  = neg_q ? -lo_q : lo_q;
    rem_fix_s  = neg_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                      fix_res_s = prod_fix_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res_s = quo_fix_s;
      default:                     fix_res_s = rem_fix_s;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = special_s ? ST_DONE : ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FIX: state_d = ST_DONE;
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs, decoded from registered state and datapath registers.
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_DONE);
    out_rd     = rd_q;
    out_result = result_q;
  end

  // Datapath next-state: capture at accept, iterate in BUSY, fix in FIX.
  always_comb begin
    op_d     = op_q;
    rd_d     = rd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    if (flush) begin
      cnt_d = cnt_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d  = op_in_s;
            rd_d  = in_rd;
            hi_d  = ZERO_S;
            lo_d  = mag1_s;
            opb_d = mag2_s;
            cnt_d = CNT_W'(XLEN);
            // Remainder takes the dividend's sign; products and quotients s1^s2.
            neg_d = (op_in_s inside {OP_REM, OP_REMU}) ? s1_s : (s1_s ^ s2_s);
            if (special_s) begin
              result_d = special_res_s;
            end else begin
              result_d = result_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_BUSY: begin
          hi_d  = hi_nxt_s;
          lo_d  = lo_nxt_s;
          cnt_d = cnt_q - CNT_ONE;
        end
        ST_FIX:  result_d = fix_res_s;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      rd_q     <= 5'd0;
      hi_q     <= ZERO_S;
      lo_q     <= ZERO_S;
      opb_q    <= ZERO_S;
      result_q <= ZERO_S;
      neg_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      op_q     <= op_d;
      rd_q     <= rd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit with an arithmetic
// reference model (128-bit products, SV signed division) and randomized ops.
module tb_muldiv_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [63:0] in_rs1_data = 64'd0;
  logic [63:0] in_rs2_data = 64'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_rd;
  logic [63:0] out_result;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_result(out_result)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RV64M result computed directly from the ISA definition.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic signed [127:0] sa, sb, ubs;
    logic [127:0] p;
    logic [63:0] r;
    sa  = {{64{a[63]}}, a};
    sb  = {{64{b[63]}}, b};
    ubs = {64'd0, b};
    case (op)
      3'd0: begin p = sa * sb; r = p[63:0]; end
      3'd1: begin p = sa * sb; r = p[127:64]; end
      3'd2: begin p = sa * ubs; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      3'd4: r = (b == 64'd0) ? ONES64 : ((a == MIN64 && b == ONES64) ? a : 64'($signed(a) / $signed(b)));
      3'd5: r = (b == 64'd0) ? ONES64 : a / b;
      3'd6: r = (b == 64'd0) ? a : ((a == MIN64 && b == ONES64) ? 64'd0 : 64'($signed(a) % $signed(b)));
      default: r = (b == 64'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic special;
    special = op[2] && ((b == 64'd0) || ((op == 3'd4 || op == 3'd6) && a == MIN64 && b == ONES64));
    return special ? 1 : XLEN + 2;
  endfunction

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = ONES64;
      2: v = MIN64;
      3: v = {32'd0, 24'd0, 8'($urandom)};
      4: v = -{48'd0, 16'($urandom)};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Drives one op, waits (bounded) for out_valid, captures it and handshakes.
  // lat counts posedges from the accept edge to the first edge that samples out_valid=1.
  task automatic do_op(input logic [2:0] op, input logic [4:0] rd, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output logic [4:0] rdo,
                       output int lat, output logic ready_low);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1_data = a; in_rs2_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 3'($urandom); in_rd = 5'($urandom);
    in_rs1_data = {$urandom, $urandom}; in_rs2_data = {$urandom, $urandom};
    ready_low = 1'b1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) ready_low = 1'b0;
    res = out_result;
    rdo = out_rd;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rd !== 5'd0 || out_result !== 64'd0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_rd=%0d out_result=%h (want 1 0 0 0)",
               in_ready, out_valid, out_rd, out_result);
    end
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[14];
    logic [63:0] res; logic [4:0] rdo, rd; int lat; logic rl;
    v[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 8'd66};
    v[1]  = '{3'd1, MIN64, MIN64, 64'h4000_0000_0000_0000, 8'd66};
    v[2]  = '{3'd3, ONES64, 64'd2, 64'd1, 8'd66};
    v[3]  = '{3'd2, ONES64, 64'd2, ONES64, 8'd66};
    v[4]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd66};
    v[5]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES64, 8'd66};
    v[6]  = '{3'd5, 64'd100, 64'd7, 64'd14, 8'd66};
    v[7]  = '{3'd7, 64'd100, 64'd7, 64'd2, 8'd66};
    v[8]  = '{3'd4, 64'd5, 64'd0, ONES64, 8'd1};
    v[9]  = '{3'd6, 64'd5, 64'd0, 64'd5, 8'd1};
    v[10] = '{3'd4, MIN64, ONES64, MIN64, 8'd1};
    v[11] = '{3'd6, MIN64, ONES64, 64'd0, 8'd1};
    v[12] = '{3'd5, 64'd5, 64'd0, ONES64, 8'd1};
    v[13] = '{3'd7, 64'd5, 64'd0, 64'd5, 8'd1};
    for (int i = 0; i < 14; i++) begin
      rd = 5'(i + 3);
      do_op(v[i].op, rd, v[i].a, v[i].b, res, rdo, lat, rl);
      checks++;
      if (res !== v[i].exp || rdo !== rd) begin
        failures++;
        $display("FAIL directed[%0d] result: got %h rd %0d, want %h rd %0d", i, res, rdo, v[i].exp, rd);
      end
      checks++;
      if (lat != int'(v[i].lat)) begin
        failures++;
        $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, v[i].lat);
      end
      checks++;
      if (rl !== 1'b1) begin
        failures++;
        $display("FAIL directed[%0d] in_ready while busy: got high, want low", i);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, res, exp; logic [2:0] op; logic [4:0] rd, rdo; int lat; logic rl;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom); rd = 5'($urandom);
      a = pick_operand(); b = pick_operand();
      exp = ref_model(op, a, b);
      do_op(op, rd, a, b, res, rdo, lat, rl);
      checks++;
      if (res !== exp || rdo !== rd || lat != ref_latency(op, a, b)) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h rd %0d lat %0d, want %h rd %0d lat %0d",
                 i, op, a, b, res, rdo, lat, exp, rd, ref_latency(op, a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_rd = 5'd17; in_rs1_data = 64'd1000; in_rs2_data = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 64'd142 || out_rd !== 5'd17 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure[%0d]: valid=%b result=%h rd=%0d in_ready=%b, want 1 %h 17 0",
                 i, out_valid, out_result, out_rd, in_ready, 64'd142);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush_reset();
    logic seen; logic [63:0] res; logic [4:0] rdo; int lat; logic rl;
    // Flush in BUSY.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_rd = 5'd9; in_rs1_data = 64'd11; in_rs2_data = 64'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush busy: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush busy result: out_valid seen high, want never");
    end
    // Flush in the same cycle as an accept.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (80) begin if (out_valid || !in_ready) seen = 1'b1; @(posedge clk); #1; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush accept: op not dropped (busy or valid seen), want idle");
    end
    // Reset in BUSY.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd4; in_rd = 5'd21; in_rs1_data = 64'd99; in_rs2_data = 64'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0 || out_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset busy: in_ready=%b out_valid=%b result=%h rd=%0d, want 1 0 0 0",
               in_ready, out_valid, out_result, out_rd);
    end
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset busy result: out_valid seen high, want never");
    end
    do_op(3'd0, 5'd4, 64'd3, 64'd4, res, rdo, lat, rl);
    checks++;
    if (res !== 64'd12 || rdo !== 5'd4 || lat != XLEN + 2) begin
      failures++;
      $display("FAIL post-reset mul: got %h rd %0d lat %0d, want 12 rd 4 lat %0d", res, rdo, lat, XLEN + 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r0, r1, a0, b0, a1, b1; logic [4:0] d0, d1; int l0, l1; logic rl;
    a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
    a1 = {$urandom, $urandom}; b1 = 64'($urandom);
    do_op(3'd1, 5'd30, a0, b0, r0, d0, l0, rl);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back ready: in_ready=%b after handshake, want 1", in_ready);
    end
    do_op(3'd6, 5'd31, a1, b1, r1, d1, l1, rl);
    checks++;
    if (r0 !== ref_model(3'd1, a0, b0) || d0 !== 5'd30 || r1 !== ref_model(3'd6, a1, b1) || d1 !== 5'd31) begin
      failures++;
      $display("FAIL back_to_back results: got %h/%0d %h/%0d, want %h/30 %h/31",
               r0, d0, r1, d1, ref_model(3'd1, a0, b0), ref_model(3'd6, a1, b1));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
